// File: rtl/rf_scoreboard_bypass.sv
// Decode-stage register file with WB->ID bypass, per-entry busy scoreboard and
// a post-reset clear sweep that zeroes the array one entry per cycle.

module rf_rd_port #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              ready,
    input  logic [ADDR_W-1:0] addr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] ent_data,
    input  logic              ent_busy,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_busy
);
    logic is_zero;
    logic hit;

    assign is_zero = (ZERO_REG != 0) && (addr == '0);
    assign hit     = wr_en && (wr_addr == addr);

    always_comb begin
        rd_data = '0;
        rd_busy = 1'b0;
        if (ready && !is_zero) begin
            rd_data = hit ? wr_data : ent_data;
            // A writeback landing this cycle resolves the hazard through the bypass.
            rd_busy = ent_busy && !hit;
        end
    end
endmodule

module rf_scoreboard_bypass #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    output logic                     init_done
);
    localparam int              DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W:0] CLR_LAST = (ADDR_W + 1)'(DEPTH - 1);

    typedef enum logic {CLEAR, READY} state_t;

    state_t             state_q, state_d;
    logic [ADDR_W:0]    clr_cnt_q, clr_cnt_d;
    logic               init_done_q, init_done_d;
    logic [DEPTH-1:0]   busy_q, busy_d;
    logic [DATA_W-1:0]  mem_q [DEPTH];
    logic [DATA_W-1:0]  mem_d [DEPTH];

    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        init_done_d = init_done_q;
        busy_d      = busy_q;
        mem_d       = mem_q;
        if (state_q == CLEAR) begin
            mem_d[clr_cnt_q[ADDR_W-1:0]] = '0;
            clr_cnt_d = clr_cnt_q + (ADDR_W + 1)'(1);
            if (clr_cnt_q == CLR_LAST) begin
                state_d     = READY;
                init_done_d = 1'b1;
            end
        end else begin
            if (wr_en && !((ZERO_REG != 0) && (wr_addr == '0)))
                mem_d[wr_addr] = wr_data;
            if (wr_en)
                busy_d[wr_addr] = 1'b0;
            // Reserve is applied after the clear so a new producer supersedes.
            if (rsv_en)
                busy_d[rsv_addr] = 1'b1;
            if (ZERO_REG != 0)
                busy_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= CLEAR;
            clr_cnt_q   <= '0;
            init_done_q <= 1'b0;
            busy_q      <= '0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            init_done_q <= init_done_d;
            busy_q      <= busy_d;
        end
    end

    // The array itself has no reset; the sweep defines its contents.
    always_ff @(posedge clk) begin
        if (!rst)
            mem_q <= mem_d;
    end

    assign init_done = init_done_q;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] addr_i;
        assign addr_i = rd_addr[i*ADDR_W +: ADDR_W];

        rf_rd_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG)
        ) u_port (
            .ready    (init_done_q),
            .addr     (addr_i),
            .wr_en    (wr_en),
            .wr_addr  (wr_addr),
            .wr_data  (wr_data),
            .ent_data (mem_q[addr_i]),
            .ent_busy (busy_q[addr_i]),
            .rd_data  (rd_data[i*DATA_W +: DATA_W]),
            .rd_busy  (rd_busy[i])
        );
    end
endmodule
